// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle computer: decodes the latched instruction
// and flags and sequences every datapath control, one state per clock.
module multicycle_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] INSTRUCTION_OUT,
    input  logic [3:0]  FLAGS,
    output logic        A3Src,
    output logic        AdrSrc,
    output logic        FlagUpdate,
    output logic        IRWrite,
    output logic        MemWrite,
    output logic        PCWrite,
    output logic        RegWrite,
    output logic        WD3Src,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  RegSrc,
    output logic [2:0]  ALUop,
    output logic [2:0]  ShiftType,
    output logic [3:0]  STATE_OUT
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        EXECS    = 4'd8,
        ALUWB    = 4'd9,
        BRANCH   = 4'd10
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic [3:0] cond_s;
    logic [1:0] op_s;
    logic       imm_s;
    logic [3:0] cmd_s;
    logic       s_bit_s;
    logic       up_s;
    logic       link_s;
    logic [2:0] shift_s;
    logic [2:0] dp_aluop_s;
    logic       cmd_legal_s;
    logic       is_cmp_s;
    logic       is_shift_s;
    logic       noop_s;
    logic       unused_s;

    // {N,Z,C,V} condition evaluation for the cond field
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        n = flags[3];
        z = flags[2];
        c = flags[1];
        v = flags[0];
        case (cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = !z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = !c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = !n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = !v;
            4'b1000: cond_pass = c & !z;
            4'b1001: cond_pass = !c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = !z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    endfunction

    assign cond_s   = INSTRUCTION_OUT[31:28];
    assign op_s     = INSTRUCTION_OUT[27:26];
    assign imm_s    = INSTRUCTION_OUT[25];
    assign cmd_s    = INSTRUCTION_OUT[24:21];
    assign s_bit_s  = INSTRUCTION_OUT[20];
    assign up_s     = INSTRUCTION_OUT[23];
    assign link_s   = INSTRUCTION_OUT[24];
    assign shift_s  = INSTRUCTION_OUT[7:5];
    assign unused_s = ^{INSTRUCTION_OUT[19:8], INSTRUCTION_OUT[4:0]};

    // Data-processing command decode: ALU operation and legality
    always_comb begin
        dp_aluop_s  = 3'b000;
        cmd_legal_s = 1'b1;
        case (cmd_s)
            4'b0100: dp_aluop_s = 3'b000;
            4'b0010: dp_aluop_s = 3'b001;
            4'b0000: dp_aluop_s = 3'b010;
            4'b1100: dp_aluop_s = 3'b011;
            4'b1010: dp_aluop_s = 3'b001;
            4'b1101: dp_aluop_s = 3'b100;
            default: cmd_legal_s = 1'b0;
        endcase
    end

    assign is_cmp_s   = (cmd_s == 4'b1010);
    assign is_shift_s = (cmd_s == 4'b1101) && !imm_s;
    // MOV-register with shift codes 101..111 and unknown classes fall through as no-ops
    assign noop_s = (op_s == 2'b11) ||
                    ((op_s == 2'b00) && !cmd_legal_s) ||
                    ((op_s == 2'b00) && is_shift_s && (shift_s > 3'd4));

    // State register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and Moore outputs; reset forces the idle vector
    always_comb begin
        state_next_s = state_r;
        A3Src        = 1'b0;
        AdrSrc       = 1'b0;
        FlagUpdate   = 1'b0;
        IRWrite      = 1'b0;
        MemWrite     = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        WD3Src       = 1'b0;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ResultSrc    = 2'b00;
        RegSrc       = 2'b00;
        ALUop        = 3'b000;
        ShiftType    = 3'b111;
        STATE_OUT    = 4'd0;
        if (reset) begin
            state_next_s = FETCH;
        end else begin
            STATE_OUT = state_r;
            case (state_r)
                FETCH: begin
                    IRWrite      = 1'b1;
                    PCWrite      = 1'b1;
                    ALUSrcB      = 2'b11;
                    ResultSrc    = 2'b10;
                    RegSrc       = 2'b10;
                    state_next_s = DECODE;
                end
                DECODE: begin
                    ALUSrcB   = 2'b11;
                    ResultSrc = 2'b10;
                    RegSrc    = 2'b10;
                    if (!cond_pass(cond_s, FLAGS) || noop_s) begin
                        state_next_s = FETCH;
                    end else begin
                        case (op_s)
                            2'b01:   state_next_s = MEMADR;
                            2'b10:   state_next_s = BRANCH;
                            2'b00:   state_next_s = is_shift_s ? EXECS : (imm_s ? EXECI : EXECR);
                            default: state_next_s = FETCH;
                        endcase
                    end
                end
                MEMADR: begin
                    ALUSrcA      = 2'b01;
                    ALUSrcB      = 2'b01;
                    ALUop        = up_s ? 3'b000 : 3'b001;
                    RegSrc       = 2'b10;
                    state_next_s = s_bit_s ? MEMREAD : MEMWRITE;
                end
                MEMREAD: begin
                    AdrSrc       = 1'b1;
                    RegSrc       = 2'b10;
                    state_next_s = MEMWB;
                end
                MEMWB: begin
                    AdrSrc       = 1'b1;
                    RegWrite     = 1'b1;
                    ResultSrc    = 2'b01;
                    RegSrc       = 2'b10;
                    state_next_s = FETCH;
                end
                MEMWRITE: begin
                    AdrSrc       = 1'b1;
                    MemWrite     = 1'b1;
                    RegSrc       = 2'b10;
                    state_next_s = FETCH;
                end
                EXECR, EXECI: begin
                    ALUSrcA      = 2'b01;
                    ALUSrcB      = (state_r == EXECI) ? 2'b01 : 2'b00;
                    ALUop        = dp_aluop_s;
                    FlagUpdate   = s_bit_s | is_cmp_s;
                    state_next_s = is_cmp_s ? FETCH : ALUWB;
                end
                EXECS: begin
                    ALUSrcA      = 2'b10;
                    ShiftType    = shift_s;
                    FlagUpdate   = s_bit_s;
                    state_next_s = ALUWB;
                end
                ALUWB: begin
                    RegWrite     = 1'b1;
                    ALUSrcA      = 2'b01;
                    state_next_s = FETCH;
                end
                BRANCH: begin
                    ALUSrcB      = 2'b01;
                    ResultSrc    = 2'b10;
                    PCWrite      = 1'b1;
                    RegWrite     = link_s;
                    A3Src        = link_s;
                    WD3Src       = link_s;
                    state_next_s = FETCH;
                end
                default: begin
                    state_next_s = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller: expected per-cycle output
// vectors are queued per instruction and compared just before each rising edge.
module tb_multicycle_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] INSTRUCTION_OUT = 32'h0000_0000;
    logic [3:0]  FLAGS = 4'b0000;
    logic        A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src;
    logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc, RegSrc;
    logic [2:0]  ALUop, ShiftType;
    logic [3:0]  STATE_OUT;

    typedef struct packed {
        logic       a3, adr, fu, irw, mw, pcw, rw, wd3;
        logic [1:0] sa, sb, rs, rgs;
        logic [2:0] aluop, sht;
        logic [3:0] st;
    } vec_t;

    vec_t       sb[$];
    logic [3:0] plan[$];
    int         checks = 0;
    int         errors = 0;

    multicycle_controller dut (
        .clock(clock), .reset(reset), .INSTRUCTION_OUT(INSTRUCTION_OUT), .FLAGS(FLAGS),
        .A3Src(A3Src), .AdrSrc(AdrSrc), .FlagUpdate(FlagUpdate), .IRWrite(IRWrite),
        .MemWrite(MemWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .WD3Src(WD3Src),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .RegSrc(RegSrc),
        .ALUop(ALUop), .ShiftType(ShiftType), .STATE_OUT(STATE_OUT)
    );

    always #5 clock = ~clock;

    function automatic vec_t idle_vec();
        vec_t v;
        v     = '0;
        v.sht = 3'b111;
        return v;
    endfunction

    // Expected outputs for one state, written from the state/output table
    function automatic vec_t ref_vec(input logic [3:0] st, input logic [31:0] ins);
        vec_t v;
        v    = idle_vec();
        v.st = st;
        case (st)
            4'd0:  begin v.irw = 1'b1; v.pcw = 1'b1; v.sb = 2'b11; v.rs = 2'b10; v.rgs = 2'b10; end
            4'd1:  begin v.sb = 2'b11; v.rs = 2'b10; v.rgs = 2'b10; end
            4'd2:  begin v.sa = 2'b01; v.sb = 2'b01; v.rgs = 2'b10;
                         v.aluop = ins[23] ? 3'b000 : 3'b001; end
            4'd3:  begin v.adr = 1'b1; v.rgs = 2'b10; end
            4'd4:  begin v.adr = 1'b1; v.rw = 1'b1; v.rs = 2'b01; v.rgs = 2'b10; end
            4'd5:  begin v.adr = 1'b1; v.mw = 1'b1; v.rgs = 2'b10; end
            4'd6, 4'd7: begin
                v.sa = 2'b01;
                v.sb = (st == 4'd7) ? 2'b01 : 2'b00;
                v.fu = ins[20] | (ins[24:21] == 4'b1010);
                case (ins[24:21])
                    4'b0010, 4'b1010: v.aluop = 3'b001;
                    4'b0000:          v.aluop = 3'b010;
                    4'b1100:          v.aluop = 3'b011;
                    4'b1101:          v.aluop = 3'b100;
                    default:          v.aluop = 3'b000;
                endcase
            end
            4'd8:  begin v.sa = 2'b10; v.sht = ins[7:5]; v.fu = ins[20]; end
            4'd9:  begin v.rw = 1'b1; v.sa = 2'b01; end
            4'd10: begin v.sb = 2'b01; v.rs = 2'b10; v.pcw = 1'b1;
                         v.rw = ins[24]; v.a3 = ins[24]; v.wd3 = ins[24]; end
            default: v = idle_vec();
        endcase
        return v;
    endfunction

    task automatic check_now(input string tag);
        vec_t obs, exp;
        obs = {A3Src, AdrSrc, FlagUpdate, IRWrite, MemWrite, PCWrite, RegWrite, WD3Src,
               ALUSrcA, ALUSrcB, ResultSrc, RegSrc, ALUop, ShiftType, STATE_OUT};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed %h", tag, obs);
        end else begin
            exp = sb.pop_front();
            assert (obs === exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h (state %0d vs %0d)",
                       tag, obs, exp, obs.st, exp.st);
            end
        end
    endtask

    // Drive one instruction for the states listed in plan, checking each cycle
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] flg, input string tag);
        foreach (plan[i]) sb.push_back(ref_vec(plan[i], ins));
        foreach (plan[i]) begin
            @(negedge clock);
            reset           = 1'b0;
            INSTRUCTION_OUT = ins;
            FLAGS           = flg;
            #4;
            check_now(tag);
        end
    endtask

    initial begin
        // reset held for two cycles: idle outputs
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            sb.push_back(idle_vec());
            #4;
            check_now("reset_idle");
        end

        plan = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        run_instr(32'hE590_0040, 4'b0000, "ldr");
        plan = '{4'd0, 4'd1, 4'd2, 4'd5};
        run_instr(32'hE500_0040, 4'b0000, "str_down");

        plan = '{4'd0, 4'd1, 4'd8, 4'd9};
        run_instr(32'hE1A0_0020, 4'b0000, "shift_lsr");
        run_instr(32'hE1A0_0000, 4'b0000, "shift_lsl");
        run_instr(32'hE1A0_0040, 4'b0000, "shift_asr");
        run_instr(32'hE1B0_0060, 4'b0000, "shift_rol_s");
        run_instr(32'hE1A0_0080, 4'b0000, "shift_ror");
        plan = '{4'd0, 4'd1};
        run_instr(32'hE1A0_00E0, 4'b0000, "shift_illegal");

        plan = '{4'd0, 4'd1, 4'd6, 4'd9};
        run_instr(32'hE081_0002, 4'b0000, "add_reg");
        run_instr(32'hE051_0002, 4'b0000, "subs_reg");
        run_instr(32'hE001_0002, 4'b0000, "and_reg");
        run_instr(32'hE181_0002, 4'b0000, "orr_reg");
        plan = '{4'd0, 4'd1, 4'd7, 4'd9};
        run_instr(32'hE281_0001, 4'b0000, "add_imm");
        run_instr(32'hE3A0_0005, 4'b0000, "mov_imm");

        plan = '{4'd0, 4'd1, 4'd6};
        run_instr(32'hE150_0001, 4'b0000, "cmp");
        plan = '{4'd0, 4'd1, 4'd10};
        run_instr(32'h0A00_0002, 4'b0100, "beq_taken");
        plan = '{4'd0, 4'd1};
        run_instr(32'h0A00_0002, 4'b0000, "beq_not_taken");
        plan = '{4'd0, 4'd1, 4'd10};
        run_instr(32'hEB00_0004, 4'b0000, "bl_al");
        plan = '{4'd0, 4'd1, 4'd10};
        run_instr(32'hCA00_0001, 4'b1001, "bgt_nv_equal");
        plan = '{4'd0, 4'd1};
        run_instr(32'hCA00_0001, 4'b1000, "bgt_nv_diff");
        run_instr(32'hEC00_0000, 4'b0000, "op11_noop");
        run_instr(32'hE1E0_0000, 4'b0000, "illegal_cmd");
        run_instr(32'hF081_0002, 4'b0000, "cond_never");

        // STR aborted by reset while in MEMADR
        plan = '{4'd0, 4'd1};
        run_instr(32'hE580_0040, 4'b0000, "str_abort");
        @(negedge clock);
        sb.push_back(ref_vec(4'd2, 32'hE580_0040));
        #1;
        check_now("str_abort_memadr");
        reset = 1'b1;
        sb.push_back(idle_vec());
        #3;
        check_now("str_abort_idle");
        plan = '{4'd0, 4'd1, 4'd6, 4'd9};
        run_instr(32'hE081_0002, 4'b0000, "after_abort");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
